// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// Operations, selected by op:
//   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
// mthi/mtlo write HI/LO at the accepting edge with zero latency. Every other
// operation latches its operands, stays busy for MULT_CYCLES or DIV_CYCLES
// cycles, and then commits HI/LO and pulses done for one cycle.
//
// Build option: define MDU_MADD_EN to implement madd/maddu. Without it,
// ops 6/7 are ignored and the accumulator adder is not built.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset
//   start  in   operation request, sampled only while idle
//   op     in   operation code (3 bits)
//   A, B   in   operands (rs, rt)
//   busy   out  operation in progress
//   done   out  one-cycle pulse after a result commit
//   hi, lo out  HI/LO registers
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5,
        OpMadd  = 3'd6,
        OpMaddu = 3'd7
    } op_e;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    // Results are computed from the latched operands and only ever reach
    // HI/LO at the committing edge.
    logic [2*WIDTH-1:0]        a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0]        prod_s, prod_u;
    logic signed [WIDTH-1:0]   quot_s, rem_s;
    logic                      div_ovf;

    always_comb begin
        a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        a_zx   = {{WIDTH{1'b0}}, a_q};
        b_zx   = {{WIDTH{1'b0}}, b_q};
        // Low 2*WIDTH bits of the sign-extended product equal the signed product.
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
        quot_s = $signed(a_q) / $signed(b_q);
        rem_s  = $signed(a_q) % $signed(b_q);
        div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op_e'(op))
                        OpMthi: hi_d = A;
                        OpMtlo: lo_d = A;
                        OpMult, OpMultu: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StBusy;
                        end
`ifdef MDU_MADD_EN
                        OpMadd, OpMaddu: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    case (op_e'(op_q))
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpDiv: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != '0) begin
                                if (div_ovf) begin
                                    lo_d = a_q;
                                    hi_d = '0;
                                end else begin
                                    lo_d = quot_s;
                                    hi_d = rem_s;
                                end
                            end
                        end
                        OpDivu: begin
                            if (b_q != '0) begin
                                lo_d = a_q / b_q;
                                hi_d = a_q % b_q;
                            end
                        end
`ifdef MDU_MADD_EN
                        OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit (WIDTH=32, 5/10 cycles).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mdu_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op and follow it to completion. hi_old/lo_old are
    // the values HI/LO must hold while busy. Returns in the done cycle, so the
    // next call exercises a back-to-back start.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp,
                          input logic [31:0] hi_old, input logic [31:0] lo_old,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, "_busy0"}, {63'd0, busy}, 64'd1);
        check_eq({tag, "_done0"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_hold"}, {hi, lo}, {hi_old, lo_old});
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check_eq({tag, "_ncyc"}, 64'(n), 64'(n_exp));
        check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
        check_eq({tag, "_hilo"}, {hi, lo}, {hi_exp, lo_exp});
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        step();
        step();
        reset = 1'b1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);

        // -2 * 3 = -6
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'h0, 32'h0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               32'h1, 32'hFFFF_FFFE);
        // -7 / 2 = -3 rem -1
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'hFFFF_FFFE,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // overflow case
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF,
               32'hFFFF_FFFD, 32'h0, 32'h8000_0000);
        // divide by zero keeps HI/LO
        run_op("divu0", 3'd3, 32'd5, 32'd0, 10, 32'h0, 32'h8000_0000,
               32'h0, 32'h8000_0000);
        // 100 / 7 = 14 rem 2
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'h0, 32'h8000_0000, 32'd2, 32'd14);
        // 7 / -2 = -3 rem 1
        run_op("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd2, 32'd14,
               32'd1, 32'hFFFF_FFFD);

        // mthi/mtlo while idle: zero latency, no busy
        op    = 3'd4;
        A     = 32'h1234_5678;
        start = 1'b1;
        step();
        check_eq("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        check_eq("mthi_busy", {63'd0, busy}, 64'd0);
        check_eq("mthi_done", {63'd0, done}, 64'd0);
        op = 3'd5;
        A  = 32'hAABB_CCDD;
        step();
        start = 1'b0;
        check_eq("mtlo_lo", {32'd0, lo}, {32'd0, 32'hAABB_CCDD});
        check_eq("mtlo_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});

        // mtlo held high through a whole mult, including the final busy edge
        op    = 3'd0;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        step();
        op = 3'd5;
        A  = 32'h0000_DEAD;
        n  = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check_eq("busymt_ncyc", 64'(n), 64'd5);
        check_eq("busymt_hilo", {hi, lo}, {32'd0, 32'd12});
        check_eq("busymt_done", {63'd0, done}, 64'd1);
        // start alongside done is accepted; done still clears
        step();
        start = 1'b0;
        check_eq("b2b_lo", {32'd0, lo}, {32'd0, 32'h0000_DEAD});
        check_eq("b2b_done", {63'd0, done}, 64'd0);
        check_eq("b2b_busy", {63'd0, busy}, 64'd0);

        // reset during the third busy cycle aborts without commit
        op    = 3'd0;
        A     = 32'd5;
        B     = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        run_op("postrst", 3'd0, 32'd6, 32'd7, 5, 32'h0, 32'h0, 32'h0, 32'd42);
        step();
        check_eq("postrst_done", {63'd0, done}, 64'd0);

        // accumulate: {0, 0xFFFFFFFF} + 1*1
        op    = 3'd4;
        A     = 32'h0;
        start = 1'b1;
        step();
        op = 3'd5;
        A  = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        check_eq("madd_pre", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`ifdef MDU_MADD_EN
        run_op("maddu", 3'd7, 32'd1, 32'd1, 5, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        // 0x1_00000000 + (-1 * 1) = 0x0_FFFFFFFF
        run_op("madd", 3'd6, 32'hFFFF_FFFF, 32'd1, 5, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF);
`else
        op    = 3'd7;
        A     = 32'd1;
        B     = 32'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("maddu_off_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 6; i++) step();
        check_eq("maddu_off_done", {63'd0, done}, 64'd0);
        check_eq("maddu_off_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
        op    = 3'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("madd_off_busy", {63'd0, busy}, 64'd0);
        check_eq("madd_off_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
